performance_counter_unit: RTL and testbench

- Programmable successor to the fixed per-event counter bank.
- NUM_COUNTERS general counters, each selects any one of NUM_EVENTS event lines. Each has enable, wrap/saturate mode, sticky overflow flag and an interrupt.
- Software reads and writes the unit through a 32-bit control-register port.
- Sits beside the core's control-register block; event lines come from pipeline and cache stages.

---
 rtl/performance_counter_unit.sv | 89 ++++++++
 tb/tb_performance_counter_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/performance_counter_unit.sv
// performance_counter_unit: programmable event counters with wrap/saturate, sticky overflow,
// coherent two-word count reads through a shared shadow, and a level overflow interrupt.
module performance_counter_unit #(
  parameter int NUM_EVENTS = 16,
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_EVENTS-1:0]           perf_event,
  input  logic                            cr_write_en,
  input  logic                            cr_read_en,
  input  logic [$clog2(NUM_COUNTERS)+1:0] cr_addr,
  input  logic [31:0]                     cr_write_data,
  output logic [31:0]                     cr_read_data,
  output logic                            perf_overflow_irq
);
  localparam int EW = $clog2(NUM_EVENTS);
  localparam int NE = 1 << EW;
  localparam int CW = NUM_COUNTERS > 1 ? $clog2(NUM_COUNTERS) : 1;
  localparam int W = COUNTER_WIDTH;
  localparam int HW = W - 32;
  logic [NE-1:0] ev;
  logic [CW-1:0] ci;
  logic [1:0] rg;
  logic [EW-1:0] sel [NUM_COUNTERS];
  logic [EW-1:0] sel_nx [NUM_COUNTERS];
  logic [W-1:0] count [NUM_COUNTERS];
  logic [W-1:0] count_nx [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] en, sat, ie, ovf, en_nx, sat_nx, ie_nx, ovf_nx;
  logic [NUM_COUNTERS-1:0] wr, ctl, ld, hit, full;
  logic [HW-1:0] shadow;
  logic [31:0] rd_nx;
  // Zero-extend so an SEL value beyond NUM_EVENTS selects a silent line.
  assign ev = NE'(perf_event);
  assign ci = CW'(cr_addr >> 2);
  assign rg = cr_addr[1:0];
  always_comb begin
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      wr[n] = cr_write_en && ci == CW'(n);
      ctl[n] = wr[n] && rg == 2'd1;
      ld[n] = wr[n] && (rg[1] || (rg == 2'd1 && cr_write_data[4]));
      hit[n] = en[n] && ev[sel[n]] && !ld[n];
      full[n] = &count[n];
      count_nx[n] = (ctl[n] && cr_write_data[4]) ? '0
                  : (wr[n] && rg == 2'd2) ? {count[n][W-1:32], cr_write_data}
                  : (wr[n] && rg == 2'd3) ? {cr_write_data[HW-1:0], count[n][31:0]}
                  : !hit[n] ? count[n]
                  : full[n] ? (sat[n] ? count[n] : '0)
                  : count[n] + W'(1);
      // A new overflow beats a simultaneous write-1-to-clear.
      ovf_nx[n] = (hit[n] && full[n]) || (ovf[n] && !(ctl[n] && cr_write_data[3]));
      en_nx[n] = ctl[n] ? cr_write_data[0] : en[n];
      sat_nx[n] = ctl[n] ? cr_write_data[1] : sat[n];
      ie_nx[n] = ctl[n] ? cr_write_data[2] : ie[n];
      sel_nx[n] = (wr[n] && rg == 2'd0) ? cr_write_data[EW-1:0] : sel[n];
    end
    rd_nx = rg == 2'd0 ? 32'(sel[ci])
          : rg == 2'd1 ? {28'd0, ovf[ci], ie[ci], sat[ci], en[ci]}
          : rg == 2'd2 ? count[ci][31:0]
          : 32'(shadow);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int n = 0; n < NUM_COUNTERS; n++) begin
        sel[n] <= '0;
        count[n] <= '0;
      end
      en <= '0;
      sat <= '0;
      ie <= '0;
      ovf <= '0;
      shadow <= '0;
      cr_read_data <= '0;
      perf_overflow_irq <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_COUNTERS; n++) begin
        sel[n] <= sel_nx[n];
        count[n] <= count_nx[n];
      end
      en <= en_nx;
      sat <= sat_nx;
      ie <= ie_nx;
      ovf <= ovf_nx;
      if (cr_read_en) cr_read_data <= rd_nx;
      if (cr_read_en && rg == 2'd2) shadow <= count[ci][W-1:32];
      perf_overflow_irq <= |(ovf & ie);
    end
endmodule

// File: tb/tb_performance_counter_unit.sv
// tb_performance_counter_unit: directed stimulus against a per-cycle behavioural model plus literal pins.
module tb_performance_counter_unit;
  localparam logic [63:0] MAX = 64'h0000_FFFF_FFFF_FFFF;
  logic clk = 0, reset = 0, cr_write_en = 0, cr_read_en = 0;
  logic [15:0] perf_event = 0;
  logic [3:0] cr_addr = 0;
  logic [31:0] cr_write_data = 0;
  logic [31:0] cr_read_data;
  logic perf_overflow_irq;
  int errs = 0, checks = 0;
  logic [63:0] m_cnt [4];
  int m_sel [4];
  bit m_en [4], m_sat [4], m_ie [4], m_ovf [4];
  logic [63:0] m_shadow;
  logic [31:0] exp_rd;
  bit exp_irq;

  always #5 clk = ~clk;

  performance_counter_unit dut (
    .clk(clk), .reset(reset), .perf_event(perf_event), .cr_write_en(cr_write_en),
    .cr_read_en(cr_read_en), .cr_addr(cr_addr), .cr_write_data(cr_write_data),
    .cr_read_data(cr_read_data), .perf_overflow_irq(perf_overflow_irq)
  );

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_cnt[n] = 0; m_sel[n] = 0; m_en[n] = 0; m_sat[n] = 0; m_ie[n] = 0; m_ovf[n] = 0;
    end
    m_shadow = 0; exp_rd = 0; exp_irq = 0;
  endtask

  task automatic model_step();
    int c, r;
    bit irq, counted, ld, novf;
    if (!reset) begin
      irq = 0;
      for (int n = 0; n < 4; n++) irq |= m_ovf[n] & m_ie[n];
      c = int'(cr_addr[3:2]);
      r = int'(cr_addr[1:0]);
      if (cr_read_en) begin
        if (r == 0) exp_rd = 32'(m_sel[c]);
        else if (r == 1) exp_rd = {28'd0, m_ovf[c], m_ie[c], m_sat[c], m_en[c]};
        else if (r == 2) begin exp_rd = m_cnt[c][31:0]; m_shadow = m_cnt[c] >> 32; end
        else exp_rd = m_shadow[31:0];
      end
      for (int n = 0; n < 4; n++) begin
        ld = cr_write_en && c == n && (r >= 2 || (r == 1 && cr_write_data[4]));
        counted = m_en[n] && perf_event[m_sel[n]] && !ld;
        novf = 0;
        if (counted) begin
          if (m_cnt[n] == MAX) begin
            novf = 1; m_ovf[n] = 1;
            if (!m_sat[n]) m_cnt[n] = 0;
          end else m_cnt[n]++;
        end
        if (cr_write_en && c == n) begin
          case (r)
            0: m_sel[n] = int'(cr_write_data[3:0]);
            1: begin
              m_en[n] = cr_write_data[0]; m_sat[n] = cr_write_data[1]; m_ie[n] = cr_write_data[2];
              if (cr_write_data[3] && !novf) m_ovf[n] = 0;
              if (cr_write_data[4]) m_cnt[n] = 0;
            end
            2: m_cnt[n] = {m_cnt[n][63:32], cr_write_data};
            default: m_cnt[n] = {16'd0, cr_write_data[15:0], m_cnt[n][31:0]};
          endcase
        end
      end
      exp_irq = irq;
    end
  endtask

  initial forever begin
    @(negedge clk);
    checks++;
    if (cr_read_data !== exp_rd) begin
      errs++; $display("FAIL model_rd_data: got %h want %h at %0t", cr_read_data, exp_rd, $time);
    end
    checks++;
    if (perf_overflow_irq !== exp_irq) begin
      errs++; $display("FAIL model_irq: got %b want %b at %0t", perf_overflow_irq, exp_irq, $time);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin errs++; $display("FAIL %s: got %h want %h", name, act, want); end
  endtask

  task automatic drive(input bit we, input bit re, input int c, input int r,
                       input logic [31:0] d, input logic [15:0] e);
    cr_write_en = we; cr_read_en = re; cr_addr = 4'(c * 4 + r); cr_write_data = d; perf_event = e;
    @(posedge clk);
    model_step();
    #1;
    cr_write_en = 0; cr_read_en = 0; perf_event = 0;
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d); drive(1, 0, c, r, d, 0); endtask
  task automatic rd(input int c, input int r); drive(0, 1, c, r, 0, 0); endtask
  task automatic pulse(input int e); drive(0, 0, 0, 0, 0, 16'(1 << e)); endtask
  task automatic idle(); drive(0, 0, 0, 0, 0, 0); endtask

  initial begin
    model_reset();
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) rd(c, r);
    lit("reset_hi3", cr_read_data, 0);
    lit("reset_irq", {31'd0, perf_overflow_irq}, 0);

    wr(0, 0, 32'hFFFF_FF05);
    wr(0, 1, 1);
    for (int i = 0; i < 10; i++) pulse(5);
    for (int i = 0; i < 7; i++) pulse(4);
    rd(0, 0); lit("sel_masked", cr_read_data, 5);
    rd(0, 2); lit("count_lo10", cr_read_data, 10);
    rd(0, 3); lit("count_hi0", cr_read_data, 0);

    wr(1, 3, 32'hFFFF);
    wr(1, 2, 32'hFFFF_FFFE);
    wr(1, 1, 5);
    pulse(0); pulse(0);
    rd(1, 1); lit("wrap_ctrl", cr_read_data, 32'hD);
    lit("wrap_irq", {31'd0, perf_overflow_irq}, 1);
    rd(1, 2); lit("wrap_lo", cr_read_data, 0);
    rd(1, 3); lit("wrap_hi", cr_read_data, 0);
    wr(1, 1, 32'hD);
    idle(); lit("irq_cleared", {31'd0, perf_overflow_irq}, 0);
    rd(1, 2); lit("wrap_preserved", cr_read_data, 0);

    wr(2, 0, 2);
    wr(2, 3, 32'hFFFF);
    wr(2, 2, 32'hFFFF_FFFE);
    wr(2, 1, 3);
    pulse(2); pulse(2); pulse(2);
    rd(2, 2); lit("sat_lo", cr_read_data, 32'hFFFF_FFFF);
    rd(2, 3); lit("sat_hi", cr_read_data, 32'hFFFF);
    rd(2, 1); lit("sat_ctrl", cr_read_data, 32'hB);

    wr(3, 0, 3);
    wr(3, 2, 32'hFFFF_FFFF);
    wr(3, 1, 1);
    rd(3, 2); lit("coh_lo", cr_read_data, 32'hFFFF_FFFF);
    pulse(3);
    rd(3, 3); lit("coh_shadow_hi", cr_read_data, 0);
    rd(3, 2); lit("coh_lo_after", cr_read_data, 0);
    rd(3, 3); lit("coh_live_hi", cr_read_data, 1);

    drive(1, 0, 0, 1, 32'h11, 16'h0020);
    rd(0, 2); lit("clear_beats_event", cr_read_data, 0);
    drive(1, 0, 2, 1, 32'hB, 16'h0004);
    rd(2, 1); lit("ovf_set_beats_clear", cr_read_data, 32'hB);
    drive(1, 1, 0, 2, 32'h1234, 0); lit("rd_pre_write", cr_read_data, 0);
    rd(0, 2); lit("rd_post_write", cr_read_data, 32'h1234);

    wr(2, 1, 7);
    idle(); lit("irq_level", {31'd0, perf_overflow_irq}, 1);
    pulse(5); pulse(5); pulse(5);
    rd(0, 2); lit("count_before_reset", cr_read_data, 32'h1237);
    reset = 1;
    model_reset();
    #1;
    lit("async_reset_rd", cr_read_data, 0);
    lit("async_reset_irq", {31'd0, perf_overflow_irq}, 0);
    pulse(5); pulse(5);
    reset = 0;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) rd(c, r);
    rd(0, 2); lit("post_reset_lo", cr_read_data, 0);
    rd(2, 1); lit("post_reset_ctrl", cr_read_data, 0);
    idle(); idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
